// File: rtl/sync_fifo_pkg.sv
// Shared defaults and flag helper for the 16x512 synchronous FIFO.
package sync_fifo_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 9;
  localparam int unsigned DEPTH      = 2**DEF_ADDR_W;
  localparam int unsigned DEF_AF_TH  = 496;
  localparam int unsigned DEF_AE_TH  = 16;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } flags_t;

  function automatic flags_t flags_from_count(input int unsigned count,
                                              input int unsigned af_th,
                                              input int unsigned ae_th,
                                              input int unsigned depth);
    flags_t f;
    f.full         = (count == depth);
    f.empty        = (count == 0);
    f.almost_full  = (count >= af_th);
    f.almost_empty = (count <= ae_th);
    return f;
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// No reset on storage or read register so it maps onto block RAM.
module fifo_sdp_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_16x512.sv
// Single-clock standard-read FIFO: pointers, occupancy, registered flags and
// error pulses around a block-RAM store. Read data appears one cycle after rd_en.
module sync_fifo_16x512
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned AF_TH  = DEF_AF_TH,
  parameter int unsigned AE_TH  = DEF_AE_TH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              srst,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow,
  output logic [ADDR_W:0]   data_count
);

  localparam int unsigned FIFO_DEPTH = 2**ADDR_W;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_next;
  logic              wr_acc;
  logic              rd_acc;
  logic              dout_clr;
  logic [DATA_W-1:0] ram_rdata;
  flags_t            flags_next;

  // Acceptance uses the registered flags, so a full FIFO still takes a read.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    count_next = data_count;
    if (wr_acc && !rd_acc)
      count_next = data_count + 1'b1;
    else if (rd_acc && !wr_acc)
      count_next = data_count - 1'b1;
  end

  assign flags_next = flags_from_count(32'(count_next), AF_TH, AE_TH, FIFO_DEPTH);

  fifo_sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc & ~srst),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (rd_acc & ~srst),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // The RAM read register has no reset; dout_clr forces zero until the first read.
  assign dout = dout_clr ? '0 : ram_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      data_count   <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      valid        <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      dout_clr     <= 1'b1;
    end else if (srst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      data_count   <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      valid        <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
      dout_clr     <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + 1'b1;
        dout_clr <= 1'b0;
      end
      data_count   <= count_next;
      full         <= flags_next.full;
      empty        <= flags_next.empty;
      almost_full  <= flags_next.almost_full;
      almost_empty <= flags_next.almost_empty;
      valid        <= rd_acc;
      overflow     <= wr_en & full;
      underflow    <= rd_en & empty;
    end
  end

endmodule

// File: tb/tb_sync_fifo_16x512.sv
// Randomized and directed bench for sync_fifo_16x512 against a queue-based model.
module tb_sync_fifo_16x512;

  localparam int M_DEPTH = 512;
  localparam int M_AF    = 496;
  localparam int M_AE    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        srst = 1'b0;
  logic [15:0] din = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] dout;
  logic        valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [9:0]  data_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] q[$];
  logic [15:0] m_dout = '0;
  logic        m_valid = 1'b0;
  logic        m_ov = 1'b0;
  logic        m_un = 1'b0;

  sync_fifo_16x512 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .srst         (srst),
    .din          (din),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .dout         (dout),
    .valid        (valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .data_count   (data_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ov    = 1'b0;
    m_un    = 1'b0;
  endtask

  // One clock of FIFO behaviour, decided from the occupancy before the edge.
  task automatic model_step(input logic w, input logic r, input logic [15:0] d, input logic s);
    int  n;
    bit  wa, ra;
    if (s) begin
      model_reset();
    end else begin
      n  = q.size();
      wa = w && (n < M_DEPTH);
      ra = r && (n > 0);
      m_ov    = w && !wa;
      m_un    = r && !ra;
      m_valid = ra;
      if (ra) m_dout = q.pop_front();
      if (wa) q.push_back(d);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = q.size();
    chk("data_count",   32'(data_count),   32'(n));
    chk("full",         32'(full),         32'(n == M_DEPTH));
    chk("empty",        32'(empty),        32'(n == 0));
    chk("almost_full",  32'(almost_full),  32'(n >= M_AF));
    chk("almost_empty", 32'(almost_empty), 32'(n <= M_AE));
    chk("valid",        32'(valid),        32'(m_valid));
    chk("overflow",     32'(overflow),     32'(m_ov));
    chk("underflow",    32'(underflow),    32'(m_un));
    chk("dout",         32'(dout),         32'(m_dout));
  endtask

  task automatic cycle(input logic w, input logic r, input logic [15:0] d, input logic s);
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    din   = d;
    srst  = s;
    model_step(w, r, d, s);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic fill_to(input int target);
    while (q.size() < target) cycle(1'b1, 1'b0, 16'($urandom), 1'b0);
  endtask

  task automatic drain_to(input int target);
    while (q.size() > target) cycle(1'b0, 1'b1, 16'h0, 1'b0);
  endtask

  task automatic async_reset_pulse();
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    srst  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #12;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Fill completely with a counting pattern, then try to overflow.
    for (int i = 0; i < 512; i++) cycle(1'b1, 1'b0, 16'(i), 1'b0);
    cycle(1'b1, 1'b0, 16'hFFFF, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);

    // Drain one past empty; the last request underflows and dout holds.
    for (int i = 0; i < 513; i++) cycle(1'b0, 1'b1, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);

    // Two 300-deep passes push both pointers across the 511->0 wrap.
    for (int p = 0; p < 2; p++) begin
      fill_to(300);
      drain_to(0);
    end

    // Simultaneous requests at empty, full and mid-level.
    cycle(1'b1, 1'b1, 16'h1234, 1'b0);
    fill_to(512);
    cycle(1'b1, 1'b1, 16'h4321, 1'b0);
    drain_to(100);
    cycle(1'b1, 1'b1, 16'h5555, 1'b0);
    drain_to(0);

    // Synchronous clear after 50 writes, then async reset after 50 writes.
    for (int i = 0; i < 50; i++) cycle(1'b1, 1'b0, 16'(i + 1000), 1'b0);
    cycle(1'b1, 1'b1, 16'hDEAD, 1'b1);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 50; i++) cycle(1'b1, 1'b0, 16'(i + 2000), 1'b0);
    async_reset_pulse();
    cycle(1'b1, 1'b0, 16'hA5A5, 1'b0);
    cycle(1'b0, 1'b1, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);

    // Random traffic with phase-dependent bias to visit both extremes.
    for (int ph = 0; ph < 4; ph++) begin
      int wp;
      case (ph)
        0: wp = 80;
        1: wp = 20;
        2: wp = 95;
        default: wp = 50;
      endcase
      for (int i = 0; i < 800; i++) begin
        logic w, r, s;
        w = ($urandom_range(99) < wp);
        r = ($urandom_range(99) < (100 - wp));
        s = ($urandom_range(399) == 0);
        cycle(w, r, 16'($urandom), s);
      end
    end
    drain_to(0);
    cycle(1'b0, 1'b1, 16'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
